// File: rtl/e1_rx_hdb3_dec_if.sv
// Symbol-in / NRZ-out signal bundle for the E1 HDB3 receive decoder.
// The master side drives sampled line symbols; the slave side is the decoder.
interface e1_rx_hdb3_dec_if;
  logic in_hi;
  logic in_lo;
  logic in_stb;
  logic out_data;
  logic out_stb;
  logic out_err;
  logic los;

  modport master (
    output in_hi, in_lo, in_stb,
    input  out_data, out_stb, out_err, los
  );

  modport slave (
    input  in_hi, in_lo, in_stb,
    output out_data, out_stb, out_err, los
  );
endinterface

// File: rtl/e1_rx_hdb3_dec.sv
// HDB3 line decoder: removes B00V/000V substitutions, flags code errors,
// and tracks loss of signal from the run length of zero symbols.
module e1_rx_hdb3_dec #(
  parameter int LOS_THRESH = 255
) (
  input  logic              clk,
  input  logic              rst,
  e1_rx_hdb3_dec_if.slave   line_if
);

  localparam int ZW = $clog2(LOS_THRESH + 1);
  localparam logic [ZW-1:0] THRESH = ZW'(LOS_THRESH);

  logic [2:0]    sr_q, sr_d;
  logic          last_pol_q, last_pol_d;       // 1 = positive pulse
  logic          last_pol_vld_q, last_pol_vld_d;
  logic          last_v_pol_q, last_v_pol_d;
  logic          last_v_vld_q, last_v_vld_d;
  logic [ZW-1:0] zcnt_q, zcnt_d;
  logic          los_q, los_d;
  logic          data_q, data_d;
  logic          stb_q, stb_d;
  logic          err_q, err_d;

  logic pos, pulse, illegal, is_v, code_err;

  always_comb begin
    pos      = line_if.in_hi & ~line_if.in_lo;
    pulse    = line_if.in_hi ^ line_if.in_lo;
    illegal  = line_if.in_hi & line_if.in_lo;
    is_v     = pulse & last_pol_vld_q & (pos == last_pol_q);
    // Too few zeros ahead of the V, or two Vs in a row of the same polarity.
    code_err = illegal
             | (is_v & (sr_q[0] | sr_q[1]))
             | (is_v & last_v_vld_q & (pos == last_v_pol_q));
  end

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path
    // through this block leaves a variable unassigned and no latch is inferred.
    sr_d           = sr_q;
    last_pol_d     = last_pol_q;
    last_pol_vld_d = last_pol_vld_q;
    last_v_pol_d   = last_v_pol_q;
    last_v_vld_d   = last_v_vld_q;
    zcnt_d         = zcnt_q;
    los_d          = los_q;
    data_d         = data_q;
    stb_d          = 1'b0;
    err_d          = 1'b0;

    if (line_if.in_stb) begin
      stb_d = 1'b1;
      err_d = code_err;

      if (is_v) begin
        data_d = 1'b0;
        sr_d   = 3'b000;
      end else begin
        data_d = sr_q[2];
        sr_d   = {sr_q[1:0], pulse};
      end

      if (pulse) begin
        last_pol_d     = pos;
        last_pol_vld_d = 1'b1;
      end
      if (is_v) begin
        last_v_pol_d = pos;
        last_v_vld_d = 1'b1;
      end

      if (pulse) begin
        zcnt_d = '0;
        los_d  = 1'b0;
      end else begin
        if (zcnt_q != THRESH) zcnt_d = zcnt_q + ZW'(1);
        if (zcnt_d == THRESH) los_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q           <= 3'b000;
      last_pol_q     <= 1'b0;
      last_pol_vld_q <= 1'b0;
      last_v_pol_q   <= 1'b0;
      last_v_vld_q   <= 1'b0;
      zcnt_q         <= '0;
      los_q          <= 1'b1;
      data_q         <= 1'b0;
      stb_q          <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      sr_q           <= sr_d;
      last_pol_q     <= last_pol_d;
      last_pol_vld_q <= last_pol_vld_d;
      last_v_pol_q   <= last_v_pol_d;
      last_v_vld_q   <= last_v_vld_d;
      zcnt_q         <= zcnt_d;
      los_q          <= los_d;
      data_q         <= data_d;
      stb_q          <= stb_d;
      err_q          <= err_d;
    end
  end

  assign line_if.out_data = data_q;
  assign line_if.out_stb  = stb_q;
  assign line_if.out_err  = err_q;
  assign line_if.los      = los_q;

endmodule

// File: tb/tb_e1_rx_hdb3_dec.sv
// Bench for e1_rx_hdb3_dec: hand-decoded symbol table plus reset and LOS
// saturation sequences, checked through an expected-output queue.
module tb_e1_rx_hdb3_dec;

  localparam int THRESH = 4;

  typedef enum logic [1:0] {S0 = 2'd0, SP = 2'd1, SN = 2'd2, SX = 2'd3} sym_e;

  typedef struct {
    sym_e sym;
    int   gap;
    logic d;
    logic e;
    logic l;
  } vec_t;

  typedef struct {
    string name;
    logic  d;
    logic  e;
    logic  l;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  e1_rx_hdb3_dec_if line_if ();

  e1_rx_hdb3_dec #(.LOS_THRESH(THRESH)) dut (
    .clk     (clk),
    .rst     (rst),
    .line_if (line_if.slave)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic add(input sym_e s, input int gap, input logic d, input logic e, input logic l);
    vec_t v;
    v.sym = s; v.gap = gap; v.d = d; v.e = e; v.l = l;
    vecs.push_back(v);
  endtask

  // Called at a negedge; drives one strobe and queues its expected output.
  task automatic drive(input sym_e s, input int gap, input string name,
                       input logic d, input logic e, input logic l);
    exp_t x;
    x.name = name; x.d = d; x.e = e; x.l = l;
    exp_q.push_back(x);
    line_if.in_hi  = (s == SP) || (s == SX);
    line_if.in_lo  = (s == SN) || (s == SX);
    line_if.in_stb = 1'b1;
    @(negedge clk);
    line_if.in_stb = 1'b0;
    line_if.in_hi  = 1'b0;
    line_if.in_lo  = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && line_if.out_stb) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_stb", 1, 0);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check({x.name, "_data"}, line_if.out_data, x.d);
        check({x.name, "_err"},  line_if.out_err,  x.e);
        check({x.name, "_los"},  line_if.los,      x.l);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    line_if.in_hi  = 1'b0;
    line_if.in_lo  = 1'b0;
    line_if.in_stb = 1'b0;

    // AMI, 14-cycle strobe spacing, then substitutions and errors back-to-back.
    add(SP, 14, 0, 0, 0); add(SN, 14, 0, 0, 0); add(SP, 14, 0, 0, 0); add(SN, 14, 1, 0, 0);
    add(S0, 14, 1, 0, 0); add(S0, 14, 1, 0, 0); add(S0, 14, 1, 0, 0); add(S0, 14, 0, 0, 1);
    for (int i = 0; i < 6; i++) add(S0, 14, 0, 0, 1);
    add(SP, 1, 0, 0, 0); add(S0, 1, 0, 0, 0); add(S0, 1, 0, 0, 0); add(S0, 1, 1, 0, 0);
    add(SP, 1, 0, 0, 0);                                   // 000V+
    add(SN, 1, 0, 0, 0); add(SP, 1, 0, 0, 0);
    add(SN, 1, 0, 0, 0); add(S0, 1, 1, 0, 0); add(S0, 1, 1, 0, 0);
    add(SN, 1, 0, 0, 0);                                   // B-00V-
    add(S0, 1, 0, 0, 0); add(S0, 1, 0, 0, 0); add(S0, 1, 0, 0, 0);
    add(SP, 1, 0, 0, 0); add(S0, 1, 0, 0, 0); add(S0, 1, 0, 0, 0); add(S0, 1, 1, 0, 0);
    add(SP, 1, 0, 0, 0);                                   // V+
    add(S0, 1, 0, 0, 0); add(S0, 1, 0, 0, 0);
    add(SP, 1, 0, 1, 0);                                   // second V+ -> error
    add(SN, 1, 0, 0, 0); add(SN, 1, 0, 1, 0);              // V right after pulse
    add(SX, 1, 0, 1, 0); add(SP, 1, 0, 0, 0); add(SX, 1, 0, 1, 0);
    add(S0, 1, 0, 0, 0); add(S0, 1, 1, 0, 0); add(S0, 1, 0, 0, 1); add(S0, 1, 0, 0, 1);

    repeat (3) @(negedge clk);
    check("rst_out_stb",  line_if.out_stb,  0);
    check("rst_out_data", line_if.out_data, 0);
    check("rst_out_err",  line_if.out_err,  0);
    check("rst_los",      line_if.los,      1);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_los", line_if.los,      1);
    check("post_rst_zcnt", 32'(dut.zcnt_q), 0);

    for (int i = 0; i < vecs.size(); i++)
      drive(vecs[i].sym, vecs[i].gap, $sformatf("vec%0d", i + 1), vecs[i].d, vecs[i].e, vecs[i].l);
    drain("table");

    // LOS saturation over a long zero run, then a pulse clears it.
    for (int i = 0; i < 300; i++) drive(S0, 1, $sformatf("sat%0d", i), 0, 0, 1);
    drain("sat");
    check("sat_zcnt", 32'(dut.zcnt_q), THRESH);
    drive(SP, 1, "los_clear", 0, 0, 0);
    drain("los_clear");

    // Mid-stream reset: out_data is 1 and los is 0 just before it.
    drive(SN, 1, "pre_rst1", 0, 0, 0); drive(S0, 1, "pre_rst2", 0, 0, 0);
    drive(S0, 1, "pre_rst3", 0, 0, 0); drive(S0, 1, "pre_rst4", 1, 0, 0);
    drain("pre_rst");
    check("pre_rst_data", line_if.out_data, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_data", line_if.out_data, 0);
    check("mid_rst_stb",  line_if.out_stb,  0);
    check("mid_rst_err",  line_if.out_err,  0);
    check("mid_rst_los",  line_if.los,      1);
    exp_q.delete();
    @(negedge clk);
    line_if.in_hi  = 1'b1;
    line_if.in_stb = 1'b1;
    @(negedge clk);
    line_if.in_hi  = 1'b0;
    line_if.in_stb = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_strobe_dropped", line_if.out_stb, 0);

    // Same polarity as the pre-reset pulse: must decode normally, not as V.
    drive(SN, 1, "post_rst1", 0, 0, 0); drive(S0, 1, "post_rst2", 0, 0, 0);
    drive(S0, 1, "post_rst3", 0, 0, 0); drive(S0, 1, "post_rst4", 1, 0, 0);
    drive(S0, 1, "post_rst5", 0, 0, 1);
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
